// File: rtl/lcd_pkg.sv
// lcd_pkg -- shared definitions for the HD44780 bus driver and LCD controller.
//   lcd_state_t / ST_*     : bus-driver state encoding
//   CLEAR_DISPLAY, RETURN_HOME : command bytes that need the long execution wait
//   LCD_T_*                : default timing constants in clock cycles
//   max_int()              : constant helper for sizing counters
//   is_long_cmd()          : true for clear/home commands (long execution wait)
package lcd_pkg;

    typedef logic [2:0] lcd_state_t;

    localparam lcd_state_t ST_POWERUP = 3'd0;
    localparam lcd_state_t ST_IDLE    = 3'd1;
    localparam lcd_state_t ST_SETUP   = 3'd2;
    localparam lcd_state_t ST_PULSE   = 3'd3;
    localparam lcd_state_t ST_HOLD    = 3'd4;
    localparam lcd_state_t ST_EXEC    = 3'd5;

    localparam logic [7:0] CLEAR_DISPLAY = 8'h01;
    localparam logic [7:0] RETURN_HOME   = 8'h02;

    localparam int LCD_T_POWERON   = 750000;
    localparam int LCD_T_SETUP     = 4;
    localparam int LCD_T_PW        = 25;
    localparam int LCD_T_HOLD      = 4;
    localparam int LCD_T_EXEC      = 2000;
    localparam int LCD_T_EXEC_LONG = 82000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // RETURN_HOME ignores bit 0, so 0x02 and 0x03 both qualify; clear is 0x01
    // exactly (0x00 shares the top seven bits and is treated the same way).
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data[7:1] == CLEAR_DISPLAY[7:1]) ||
                       (data[7:1] == RETURN_HOME[7:1]));
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter -- loadable down-counter shared by all timed driver states.
//   clk, reset    : clock, asynchronous active-high reset (count -> 0)
//   load_i        : load strobe, takes priority over counting
//   load_val_i    : value loaded on load_i
//   zero_o        : count is zero
// The count saturates at zero so it can never wrap.
module lcd_delay_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver -- write-only HD44780 bus driver (8-bit or 4-bit bus).
//   clk, reset           : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  : byte handshake from upstream
//   cmd_rs, cmd_data     : register select (0 cmd, 1 data) and byte to write
//   lcd_rs, lcd_rw,
//   lcd_en, lcd_data     : HD44780 pins (lcd_rw tied low)
//   busy                 : ~cmd_ready
// Each byte (or nibble in 4-bit mode) goes through SETUP/PULSE/HOLD, then an
// execution wait (long for clear/home) before the next byte is accepted.
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int MODE4       = 0,
    parameter int T_POWERON   = LCD_T_POWERON,
    parameter int T_SETUP     = LCD_T_SETUP,
    parameter int T_PW        = LCD_T_PW,
    parameter int T_HOLD      = LCD_T_HOLD,
    parameter int T_EXEC      = LCD_T_EXEC,
    parameter int T_EXEC_LONG = LCD_T_EXEC_LONG
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       busy
);

    localparam int MAX_T = max_int(max_int(max_int(T_POWERON, T_SETUP),
                                           max_int(T_PW, T_HOLD)),
                                   max_int(T_EXEC, T_EXEC_LONG));
    localparam int CW = $clog2(MAX_T) + 1;

    // A state lasting T cycles is entered with T-1 loaded and left when the
    // counter reads zero.
    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_PW    = CW'(T_PW - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(T_EXEC_LONG - 1);
    // The counter is zero coming out of reset, so the first POWERUP cycle is
    // spent loading; the remaining T_POWERON-1 cycles are counted down.
    localparam logic [CW-1:0] LD_PWR   = CW'((T_POWERON >= 2) ? (T_POWERON - 2) : 0);

    lcd_state_t  state_q, state_d;
    logic        ready_q;
    logic        en_q;
    logic        lrs_q, lrs_d;
    logic [7:0]  ldat_q, ldat_d;
    logic [7:0]  byte_q, byte_d;
    logic        brs_q, brs_d;
    logic        nib_q, nib_d;
    logic        armed_q, armed_d;
    logic        ld;
    logic [CW-1:0] ld_val;
    logic        cnt_zero;

    // Value placed on the bus for the first (second=0) or second nibble.
    function automatic logic [7:0] bus_word(input logic [7:0] b, input logic second);
        if (MODE4 != 0) begin
            return second ? {b[3:0], 4'h0} : {b[7:4], 4'h0};
        end
        return b;
    endfunction

    lcd_delay_counter #(
        .W (CW)
    ) u_delay (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ld),
        .load_val_i (ld_val),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        nib_d   = nib_q;
        armed_d = armed_q;
        byte_d  = byte_q;
        brs_d   = brs_q;
        lrs_d   = lrs_q;
        ldat_d  = ldat_q;
        ld      = 1'b0;
        ld_val  = '0;

        case (state_q)
            ST_POWERUP: begin
                if (!armed_q) begin
                    if (T_POWERON == 1) begin
                        state_d = ST_IDLE;
                    end else begin
                        armed_d = 1'b1;
                        ld      = 1'b1;
                        ld_val  = LD_PWR;
                    end
                end else if (cnt_zero) begin
                    armed_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    byte_d  = cmd_data;
                    brs_d   = cmd_rs;
                    lrs_d   = cmd_rs;
                    ldat_d  = bus_word(cmd_data, 1'b0);
                    nib_d   = 1'b0;
                    ld      = 1'b1;
                    ld_val  = LD_SETUP;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (cnt_zero) begin
                    ld      = 1'b1;
                    ld_val  = LD_PW;
                    state_d = ST_PULSE;
                end
            end

            ST_PULSE: begin
                if (cnt_zero) begin
                    ld      = 1'b1;
                    ld_val  = LD_HOLD;
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (cnt_zero) begin
                    if ((MODE4 != 0) && !nib_q) begin
                        // Bus changes only here, between nibble sequences.
                        nib_d   = 1'b1;
                        ldat_d  = bus_word(byte_q, 1'b1);
                        ld      = 1'b1;
                        ld_val  = LD_SETUP;
                        state_d = ST_SETUP;
                    end else begin
                        nib_d   = 1'b0;
                        ld      = 1'b1;
                        ld_val  = is_long_cmd(brs_q, byte_q) ? LD_LONG : LD_EXEC;
                        state_d = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_POWERUP;
            end
        endcase
    end

    // ready and enable are registered decodes of the next state, so they are
    // glitch-free and track state_q exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_POWERUP;
            ready_q <= 1'b0;
            en_q    <= 1'b0;
            lrs_q   <= 1'b0;
            ldat_q  <= 8'h00;
            byte_q  <= 8'h00;
            brs_q   <= 1'b0;
            nib_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
            en_q    <= (state_d == ST_PULSE);
            lrs_q   <= lrs_d;
            ldat_q  <= ldat_d;
            byte_q  <= byte_d;
            brs_q   <= brs_d;
            nib_q   <= nib_d;
            armed_q <= armed_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = ~ready_q;
    assign lcd_en    = en_q;
    assign lcd_rs    = lrs_q;
    assign lcd_data  = ldat_q;
    assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_bus_driver.sv
module tb_lcd_bus_driver;

    localparam int TP = 10;
    localparam int TS = 2;
    localparam int TW = 3;
    localparam int TH = 2;
    localparam int TE = 5;
    localparam int TL = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       v8 = 1'b0, r8i = 1'b0;
    logic [7:0] d8i = 8'h00;
    logic       rdy8, rs8, rw8, en8, busy8;
    logic [7:0] dat8;

    logic       v4 = 1'b0, r4i = 1'b0;
    logic [7:0] d4i = 8'h00;
    logic       rdy4, rs4, rw4, en4, busy4;
    logic [7:0] dat4;

    lcd_bus_driver #(
        .MODE4(0), .T_POWERON(TP), .T_SETUP(TS), .T_PW(TW), .T_HOLD(TH),
        .T_EXEC(TE), .T_EXEC_LONG(TL)
    ) u8 (
        .clk(clk), .reset(reset), .cmd_valid(v8), .cmd_ready(rdy8),
        .cmd_rs(r8i), .cmd_data(d8i), .lcd_rs(rs8), .lcd_rw(rw8),
        .lcd_en(en8), .lcd_data(dat8), .busy(busy8)
    );

    lcd_bus_driver #(
        .MODE4(1), .T_POWERON(TP), .T_SETUP(TS), .T_PW(TW), .T_HOLD(TH),
        .T_EXEC(TE), .T_EXEC_LONG(TL)
    ) u4 (
        .clk(clk), .reset(reset), .cmd_valid(v4), .cmd_ready(rdy4),
        .cmd_rs(r4i), .cmd_data(d4i), .lcd_rs(rs4), .lcd_rw(rw4),
        .lcd_en(en4), .lcd_data(dat4), .busy(busy4)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic g_rdy(input bit m);  return m ? rdy4  : rdy8;  endfunction
    function automatic logic g_en(input bit m);   return m ? en4   : en8;   endfunction
    function automatic logic g_rs(input bit m);   return m ? rs4   : rs8;   endfunction
    function automatic logic g_rw(input bit m);   return m ? rw4   : rw8;   endfunction
    function automatic logic g_busy(input bit m); return m ? busy4 : busy8; endfunction
    function automatic logic [7:0] g_dat(input bit m); return m ? dat4 : dat8; endfunction

    task automatic drive(input bit m, input logic v, input logic rs, input logic [7:0] d);
        if (m) begin
            v4 = v; r4i = rs; d4i = d;
        end else begin
            v8 = v; r8i = rs; d8i = d;
        end
    endtask

    // One transfer: waits for ready, offers the byte for one edge, then
    // scrambles the inputs and observes the bus at every falling edge until
    // ready returns.
    task automatic run_xfer(input bit m, input logic rs, input logic [7:0] d,
                            output int low, output int en_cyc, output int npulse,
                            output int first_en, output logic [7:0] pd0,
                            output logic [7:0] pd1, output logic prs,
                            output logic [7:0] dat_c1, output logic [7:0] dat_hold,
                            output int side_err);
        int   guard;
        int   c;
        logic prev_en;
        low = 0; en_cyc = 0; npulse = 0; first_en = -1;
        pd0 = 8'h00; pd1 = 8'h00; prs = 1'b0;
        dat_c1 = 8'h00; dat_hold = 8'h00; side_err = 0;
        guard = 0;
        @(negedge clk);
        while (!g_rdy(m) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!g_rdy(m)) begin
            check("ready_wait_timeout", 32'd0, 32'd1);
            return;
        end
        drive(m, 1'b1, rs, d);
        @(negedge clk);
        drive(m, 1'b0, ~rs, ~d);
        c = 1;
        prev_en = 1'b0;
        while (!g_rdy(m) && c < 400) begin
            low++;
            if (g_en(m)) begin
                en_cyc++;
                if (!prev_en) begin
                    if (npulse == 0) begin
                        pd0 = g_dat(m);
                        prs = g_rs(m);
                        first_en = c;
                    end else begin
                        pd1 = g_dat(m);
                    end
                    npulse++;
                end
            end
            if (c == 1) dat_c1 = g_dat(m);
            if (c == TS + TW + TH) dat_hold = g_dat(m);
            if (g_busy(m) !== ~g_rdy(m) || g_rw(m) !== 1'b0) side_err++;
            prev_en = g_en(m);
            @(negedge clk);
            c++;
        end
    endtask

    typedef struct {
        bit         m;
        logic       rs;
        logic [7:0] d;
        int         low;
        int         npulse;
        logic [7:0] n1;
        logic [7:0] n2;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int low, en_cyc, npulse, first_en, side_err, cnt, en_seen, guard;
        logic [7:0] pd0, pd1, dat_c1, dat_hold;
        logic prs;
        logic [7:0] bb[3];
        logic [7:0] seen[3];
        int acc_t[3];
        int idx, nseen, busy_total, c;
        logic prev_rdy, prev_en;

        vecs[0] = '{1'b0, 1'b1, 8'h41, 12, 1, 8'h41, 8'h41};
        vecs[1] = '{1'b0, 1'b0, 8'h01, 27, 1, 8'h01, 8'h01};
        vecs[2] = '{1'b0, 1'b1, 8'h01, 12, 1, 8'h01, 8'h01};
        vecs[3] = '{1'b0, 1'b0, 8'h02, 27, 1, 8'h02, 8'h02};
        vecs[4] = '{1'b0, 1'b0, 8'h03, 27, 1, 8'h03, 8'h03};
        vecs[5] = '{1'b0, 1'b0, 8'h04, 12, 1, 8'h04, 8'h04};
        vecs[6] = '{1'b0, 1'b0, 8'h81, 12, 1, 8'h81, 8'h81};
        vecs[7] = '{1'b1, 1'b1, 8'h4A, 19, 2, 8'h40, 8'hA0};
        vecs[8] = '{1'b1, 1'b0, 8'h01, 34, 2, 8'h00, 8'h10};
        vecs[9] = '{1'b1, 1'b0, 8'h38, 19, 2, 8'h30, 8'h80};

        // Reset state, then power-on wait
        repeat (3) @(negedge clk);
        check("rst_ready8", rdy8, 1'b0);
        check("rst_en8", en8, 1'b0);
        check("rst_rs8", rs8, 1'b0);
        check("rst_rw8", rw8, 1'b0);
        check("rst_data8", dat8, 8'h00);
        check("rst_busy8", busy8, 1'b1);
        check("rst_ready4", rdy4, 1'b0);
        check("rst_data4", dat4, 8'h00);
        reset = 1'b0;
        cnt = 0; en_seen = 0;
        while (cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
            if (en8 || en4) en_seen++;
            if (rdy8) break;
        end
        check("poweron_cycles", cnt, TP);
        check("poweron_en_quiet", en_seen, 0);
        check("poweron_ready4", rdy4, 1'b1);

        // Table of single transfers
        for (int i = 0; i < 10; i++) begin
            run_xfer(vecs[i].m, vecs[i].rs, vecs[i].d, low, en_cyc, npulse, first_en,
                     pd0, pd1, prs, dat_c1, dat_hold, side_err);
            check($sformatf("v%0d_ready_low", i), low, vecs[i].low);
            check($sformatf("v%0d_pulses", i), npulse, vecs[i].npulse);
            check($sformatf("v%0d_en_cycles", i), en_cyc, vecs[i].npulse * TW);
            check($sformatf("v%0d_first_en", i), first_en, TS + 1);
            check($sformatf("v%0d_pulse1_data", i), pd0, vecs[i].n1);
            if (vecs[i].npulse == 2)
                check($sformatf("v%0d_pulse2_data", i), pd1, vecs[i].n2);
            check($sformatf("v%0d_rs", i), prs, vecs[i].rs);
            check($sformatf("v%0d_setup_data", i), dat_c1, vecs[i].n1);
            check($sformatf("v%0d_hold_data", i), dat_hold, vecs[i].n1);
            check($sformatf("v%0d_busy_rw", i), side_err, 0);
            check($sformatf("v%0d_idle_data", i), g_dat(vecs[i].m), vecs[i].n2);
            check($sformatf("v%0d_idle_en", i), g_en(vecs[i].m), 1'b0);
        end

        // Back-to-back bytes with cmd_valid held high
        bb[0] = 8'h31; bb[1] = 8'h32; bb[2] = 8'h33;
        seen[0] = 8'h00; seen[1] = 8'h00; seen[2] = 8'h00;
        acc_t[0] = 0; acc_t[1] = 0; acc_t[2] = 0;
        guard = 0;
        @(negedge clk);
        while (!rdy8 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        drive(1'b0, 1'b1, 1'b1, bb[0]);
        idx = 0; nseen = 0; busy_total = 0; c = 0;
        prev_rdy = rdy8; prev_en = 1'b0;
        while (c < 200) begin
            @(negedge clk);
            c++;
            if (prev_rdy && idx < 3) begin
                acc_t[idx] = c;
                idx++;
                if (idx < 3) drive(1'b0, 1'b1, 1'b1, bb[idx]);
                else         drive(1'b0, 1'b0, 1'b0, 8'h00);
            end
            if (!rdy8) busy_total++;
            if (en8 && !prev_en) begin
                if (nseen < 3) seen[nseen] = dat8;
                nseen++;
            end
            prev_rdy = rdy8;
            prev_en = en8;
            if (idx == 3 && rdy8) break;
        end
        check("b2b_accepted", idx, 3);
        check("b2b_gap1", acc_t[1] - acc_t[0], 13);
        check("b2b_gap2", acc_t[2] - acc_t[1], 13);
        check("b2b_busy_span", busy_total, 36);
        check("b2b_pulses", nseen, 3);
        check("b2b_byte0", seen[0], 8'h31);
        check("b2b_byte1", seen[1], 8'h32);
        check("b2b_byte2", seen[2], 8'h33);

        // Reset during PULSE
        guard = 0;
        @(negedge clk);
        while (!rdy8 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        drive(1'b0, 1'b1, 1'b1, 8'h55);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        guard = 0;
        while (!en8 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("midrst_reached_pulse", en8, 1'b1);
        reset = 1'b1;
        #1;
        check("midrst_en_async", en8, 1'b0);
        check("midrst_ready", rdy8, 1'b0);
        check("midrst_data", dat8, 8'h00);
        check("midrst_rs", rs8, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0; en_seen = 0;
        while (cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
            if (en8) en_seen++;
            if (rdy8) break;
        end
        check("midrst_poweron_cycles", cnt, TP);
        check("midrst_no_pulse", en_seen, 0);
        en_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (en8) en_seen++;
        end
        check("midrst_idle_no_pulse", en_seen, 0);
        check("midrst_idle_data", dat8, 8'h00);

        run_xfer(1'b0, 1'b0, 8'h55, low, en_cyc, npulse, first_en,
                 pd0, pd1, prs, dat_c1, dat_hold, side_err);
        check("post_rst_ready_low", low, 12);
        check("post_rst_pulses", npulse, 1);
        check("post_rst_data", pd0, 8'h55);
        check("post_rst_rs", prs, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
